// File: rtl/ads1292_spi_emulator_if.sv
// SPI bus plus the START/RESETN/DRDY side pins between an ADS1292 master and the emulator.
interface ads1292_spi_emulator_if;
  logic sclk;
  logic csn;
  logic mosi;
  logic miso;
  logic start;
  logic resetn;
  logic drdy;

  modport slave (
    input  sclk, csn, mosi, start, resetn,
    output miso, drdy
  );

  modport master (
    output sclk, csn, mosi, start, resetn,
    input  miso, drdy
  );
endinterface

// File: rtl/ads1292_spi_emulator.sv
// ADS1292 SPI responder: command decode, 12-entry register file and a DRDY-paced
// deterministic sample stream (ch1 = counter, ch2 = its complement).
//
// state   | meaning
// S_CMD   | waiting for an opcode byte
// S_CNT   | RREG/WREG count byte expected
// S_WDATA | receiving register write data
// S_RDATA | shifting out register read data
module ads1292_spi_emulator #(
  parameter int         DRDY_PERIOD = 4000,
  parameter logic [7:0] DEVICE_ID   = 8'h53
) (
  input logic                    clk,
  input logic                    rst,
  ads1292_spi_emulator_if.slave  spi
);

  localparam int CNT_W = $clog2(DRDY_PERIOD);

  typedef enum logic [1:0] {S_CMD, S_CNT, S_WDATA, S_RDATA} state_t;

  logic [1:0]  sclk_sync, csn_sync, mosi_sync, start_sync, resetn_sync;
  logic        sclk_q, csn_q;
  logic        sclk_s, csn_s, mosi_s, start_s, resetn_s;
  logic        srst;
  logic        sclk_rise, sclk_fall, csn_fall, byte_done;
  logic [7:0]  rx_byte;

  state_t      state;
  logic [4:0]  addr, cnt;
  logic        is_read;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic        xfer_active;
  logic [71:0] tx_sr;
  logic        miso_q, drdy_q;
  logic        rdatac, conv_cmd;
  logic [CNT_W-1:0] per_cnt;
  logic [23:0] smp;
  logic [71:0] frame, new_frame;
  logic        run, tc, pre_tc;
  logic [7:0]  regs [0:11];
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;

  function automatic logic [7:0] reg_default(input int i);
    case (i)
      0:       reg_default = DEVICE_ID;
      1:       reg_default = 8'h02;
      2:       reg_default = 8'h80;
      3:       reg_default = 8'h10;
      9, 10:   reg_default = 8'h02;
      11:      reg_default = 8'h0C;
      default: reg_default = 8'h00;
    endcase
  endfunction

  // Synchronizers only answer to the board reset so RESETN itself keeps being sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync   <= 2'b00;
      csn_sync    <= 2'b11;
      mosi_sync   <= 2'b00;
      start_sync  <= 2'b00;
      resetn_sync <= 2'b11;
      sclk_q      <= 1'b0;
      csn_q       <= 1'b1;
    end else begin
      sclk_sync   <= {sclk_sync[0], spi.sclk};
      csn_sync    <= {csn_sync[0], spi.csn};
      mosi_sync   <= {mosi_sync[0], spi.mosi};
      start_sync  <= {start_sync[0], spi.start};
      resetn_sync <= {resetn_sync[0], spi.resetn};
      sclk_q      <= sclk_sync[1];
      csn_q       <= csn_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign csn_s     = csn_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign start_s   = start_sync[1];
  assign resetn_s  = resetn_sync[1];
  assign srst      = rst | ~resetn_s;

  assign sclk_rise = sclk_s & ~sclk_q & ~csn_s;
  assign sclk_fall = ~sclk_s & sclk_q & ~csn_s;
  assign csn_fall  = ~csn_s & csn_q;
  assign byte_done = sclk_fall & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_s};

  assign run       = start_s | conv_cmd;
  assign tc        = run & (per_cnt == CNT_W'(DRDY_PERIOD - 1));
  assign pre_tc    = run & (per_cnt == CNT_W'(DRDY_PERIOD - 2));
  assign new_frame = {24'hC00000, smp, ~smp};

  // The count byte preloads the first register; every later read byte preloads the next one.
  assign rd_addr = (state == S_CNT) ? addr : addr + 5'd1;

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr <= 5'd11) rd_data = regs[rd_addr[3:0]];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= S_CMD;
      addr        <= 5'd0;
      cnt         <= 5'd0;
      is_read     <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_sr       <= 7'd0;
      xfer_active <= 1'b0;
      tx_sr       <= 72'd0;
      miso_q      <= 1'b0;
      drdy_q      <= 1'b1;
      rdatac      <= 1'b1;
      conv_cmd    <= 1'b0;
      per_cnt     <= '0;
      smp         <= 24'd0;
      frame       <= 72'd0;
      for (int i = 0; i < 12; i++) regs[i] <= reg_default(i);
    end else begin
      if (!run || tc) per_cnt <= '0;
      else            per_cnt <= per_cnt + CNT_W'(1);

      if (tc) begin
        frame <= new_frame;
        smp   <= smp + 24'd1;
      end

      // An unread frame gets a one-cycle high pulse so the next falling edge is visible.
      if (tc)                     drdy_q <= 1'b0;
      else if (pre_tc || sclk_fall) drdy_q <= 1'b1;

      if (csn_s) begin
        bit_cnt     <= 3'd0;
        rx_sr       <= 7'd0;
        xfer_active <= 1'b0;
        state       <= S_CMD;
        tx_sr       <= 72'd0;
        miso_q      <= 1'b0;
      end else begin
        if (sclk_fall) begin
          bit_cnt     <= bit_cnt + 3'd1;
          rx_sr       <= rx_byte[6:0];
          xfer_active <= 1'b1;
        end

        if (sclk_rise) begin
          miso_q <= tx_sr[71];
          tx_sr  <= {tx_sr[70:0], 1'b0};
        end

        if (byte_done) begin
          case (state)
            S_CMD: begin
              case (rx_byte)
                8'h08: conv_cmd <= 1'b1;
                8'h0A: conv_cmd <= 1'b0;
                8'h10: rdatac   <= 1'b1;
                8'h11: rdatac   <= 1'b0;
                8'h12: begin
                  if (!rdatac) begin
                    tx_sr  <= frame;
                    miso_q <= frame[71];
                  end
                end
                default: begin
                  if (!rdatac && (rx_byte[7:5] == 3'b001 || rx_byte[7:5] == 3'b010)) begin
                    addr    <= rx_byte[4:0];
                    is_read <= rx_byte[5];
                    state   <= S_CNT;
                  end
                end
              endcase
            end
            S_CNT: begin
              cnt <= rx_byte[4:0];
              if (is_read) begin
                state  <= S_RDATA;
                tx_sr  <= {rd_data, 64'd0};
                miso_q <= rd_data[7];
              end else begin
                state <= S_WDATA;
              end
            end
            S_RDATA: begin
              addr <= addr + 5'd1;
              if (cnt == 5'd0) begin
                state <= S_CMD;
              end else begin
                cnt    <= cnt - 5'd1;
                tx_sr  <= {rd_data, 64'd0};
                miso_q <= rd_data[7];
              end
            end
            S_WDATA: begin
              if (addr != 5'd0 && addr <= 5'd11) regs[addr[3:0]] <= rx_byte;
              addr <= addr + 5'd1;
              if (cnt == 5'd0) state <= S_CMD;
              else             cnt   <= cnt - 5'd1;
            end
            default: state <= S_CMD;
          endcase
        end

        if (csn_fall && rdatac) begin
          tx_sr  <= frame;
          miso_q <= frame[71];
        end

        // Master already waiting with CSN low: hand it the new frame directly.
        if (tc && rdatac && !xfer_active) begin
          tx_sr  <= new_frame;
          miso_q <= new_frame[71];
        end
      end
    end
  end

  assign spi.miso = miso_q;
  assign spi.drdy = drdy_q;

endmodule
